// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard control, next-PC input, instruction memory port and F/D outputs.
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic [31:0] nextPC;
   logic [31:0] i_inst_rdata;
   logic [31:0] i_inst_addr;
   logic [31:0] F_PC;
   logic [31:0] D_Instr;
   logic [31:0] D_PC;
   logic        D_valid;
   logic [4:0]  D_ExcCode;

   // Driven by the hazard unit, next-PC selector and instruction memory.
   modport master (
      output stall, flush, nextPC, i_inst_rdata,
      input  i_inst_addr, F_PC, D_Instr, D_PC, D_valid, D_ExcCode
   );

   modport slave (
      input  stall, flush, nextPC, i_inst_rdata,
      output i_inst_addr, F_PC, D_Instr, D_PC, D_valid, D_ExcCode
   );
endinterface

// File: rtl/fetch_stage.sv
// MIPS fetch stage: program counter plus F/D pipeline register with stall/flush.
// Optional fetch address check (AdEL) enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.slave  bus
);

   localparam logic [4:0] EXC_ADEL = 5'd4;

   logic [31:0] f_pc_p0;
   logic [31:0] d_instr_p1;
   logic [31:0] d_pc_p1;
   logic        vld_p1;
   logic [4:0]  d_exc_p1;

   logic        fetch_fault;
   logic [31:0] fetch_instr;
   logic [4:0]  fetch_exc;

   function automatic logic addr_fault(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
   endfunction

`ifdef FETCH_ADDR_CHECK_EN
   assign fetch_fault = addr_fault(f_pc_p0);
`else
   assign fetch_fault = 1'b0;
`endif

   assign fetch_instr = fetch_fault ? 32'd0 : bus.i_inst_rdata;
   assign fetch_exc   = fetch_fault ? EXC_ADEL : 5'd0;

   // Stage F: PC register, advanced from the next-PC selector unless stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_pc_p0 <= RESET_PC;
      end else if (!bus.stall) begin
         f_pc_p0 <= bus.nextPC;
      end
   end

   // Stage F/D: flush beats stall here; the bubble still records its PC for EPC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_instr_p1 <= 32'd0;
         d_pc_p1    <= 32'd0;
         vld_p1     <= 1'b0;
         d_exc_p1   <= 5'd0;
      end else if (bus.flush) begin
         d_instr_p1 <= 32'd0;
         d_pc_p1    <= f_pc_p0;
         vld_p1     <= 1'b0;
         d_exc_p1   <= 5'd0;
      end else if (!bus.stall) begin
         d_instr_p1 <= fetch_instr;
         d_pc_p1    <= f_pc_p0;
         vld_p1     <= 1'b1;
         d_exc_p1   <= fetch_exc;
      end
   end

   assign bus.i_inst_addr = f_pc_p0;
   assign bus.F_PC        = f_pc_p0;
   assign bus.D_Instr     = d_instr_p1;
   assign bus.D_PC        = d_pc_p1;
   assign bus.D_valid     = vld_p1;
   assign bus.D_ExcCode   = d_exc_p1;

endmodule
